// File: rtl/ocp_copy_engine_pkg.sv
// ---------------------------------------------------------------------------
// ocp_copy_engine_pkg
//   Shared OCP constants and bus widths for the copy engine slice.
//   Contents:
//     ADDR_WIDTH / DATA_WIDTH / BEN_WIDTH  bus widths (32-bit byte address,
//                                          32-bit data, one enable per byte)
//     OCP_CMD_*                            MCmd encodings (IDLE/WRITE/READ)
//     OCP_RESP_*                           SResp encodings (NULL/DVA/FAIL/ERR)
//     WORD_BYTES                           address stride between words
//     word_align()                         clears the byte-offset bits
// ---------------------------------------------------------------------------
package ocp_copy_engine_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);
  localparam logic [BEN_WIDTH-1:0]  BEN_ALL    = '1;

  // Word transfers only: the two byte-offset bits are always forced to zero.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage : ocp_copy_engine_pkg

// File: rtl/ocp_copy_engine.sv
// ---------------------------------------------------------------------------
// ocp_copy_engine
//   OCP initiator that copies a block of 32-bit words from a source region to
//   a destination region with one outstanding transaction at a time
//   (read word, write word, repeat). Used for boot shadowing of ROM into RAM
//   and for CPU-directed memory-to-memory moves.
//
//   Optional build macro: OCP_COPY_CSUM_EN
//     defined   -> o_csum port present; XOR of every word read with a DVA
//                  response since the last accepted start (valid at o_done,
//                  including words read before an abort).
//     undefined -> no o_csum port and no accumulator.
//
//   Ports
//     clk, nrst        clock; asynchronous active-low reset
//     i_start          start pulse, only sampled while idle
//     i_src_addr       source byte address (bits [1:0] ignored)
//     i_dst_addr       destination byte address (bits [1:0] ignored)
//     i_count          number of words to copy (0 = finish without bus traffic)
//     o_busy           high from start accept until the done pulse
//     o_done           one-cycle pulse at completion or abort
//     o_error          sticky abort flag, cleared by the next accepted start
//     o_MAddr/o_MCmd/o_MData/o_MByteEn   OCP master request (registered)
//     i_SCmdAccept     slave accepts the current command at the clock edge
//     i_SData/i_SResp  slave read data and response
//     o_csum           XOR checksum of read data (OCP_COPY_CSUM_EN only)
//
//   Timing with a zero-wait slave: 4 cycles per word; o_done is high in the
//   cycle 4N+2 after the cycle in which i_start was sampled.
// ---------------------------------------------------------------------------
module ocp_copy_engine
  import ocp_copy_engine_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [CNT_W-1:0]      i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
`ifdef OCP_COPY_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] o_csum
`endif
);

  // FSM encodings are private to this block.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [CNT_W-1:0]      remaining_q;

  // Post-increment addresses; the adder width makes them wrap modulo
  // 2**ADDR_WIDTH with no special handling.
  logic [ADDR_WIDTH-1:0] src_next;
  logic [ADDR_WIDTH-1:0] dst_next;
  assign src_next = src_q + WORD_BYTES;
  assign dst_next = dst_q + WORD_BYTES;

  // The write-data register o_MData doubles as the capture register for the
  // word returned by the read, so no separate data buffer is kept.
  // NOTE: sequential state is assigned with <= only, so every branch below
  // sees the values from before this clock edge regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the address/count datapath is reset along with the control
      // state so that a mid-transfer reset leaves no stale context behind.
      state       <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_MAddr     <= '0;
      o_MCmd      <= OCP_CMD_IDLE;
      o_MData     <= '0;
      o_MByteEn   <= '0;
`ifdef OCP_COPY_CSUM_EN
      o_csum      <= '0;
`endif
    end else begin
      o_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            src_q       <= word_align(i_src_addr);
            dst_q       <= word_align(i_dst_addr);
            remaining_q <= i_count;
            o_error     <= 1'b0;
            o_busy      <= 1'b1;
`ifdef OCP_COPY_CSUM_EN
            o_csum      <= '0;
`endif
            if (i_count == '0) begin
              state <= ST_FIN;
            end else begin
              state     <= ST_RD_CMD;
              o_MCmd    <= OCP_CMD_READ;
              o_MAddr   <= word_align(i_src_addr);
              o_MByteEn <= BEN_ALL;
            end
          end
        end

        // Command, address and byte enables stay untouched until accepted.
        ST_RD_CMD: begin
          if (i_SCmdAccept) begin
            state     <= ST_RD_RESP;
            o_MCmd    <= OCP_CMD_IDLE;
            o_MByteEn <= '0;
          end
        end

        ST_RD_RESP: begin
          case (i_SResp)
            OCP_RESP_DVA: begin
              state     <= ST_WR_CMD;
              o_MCmd    <= OCP_CMD_WRITE;
              o_MAddr   <= dst_q;
              o_MData   <= i_SData;
              o_MByteEn <= BEN_ALL;
`ifdef OCP_COPY_CSUM_EN
              o_csum    <= o_csum ^ i_SData;
`endif
            end
            OCP_RESP_FAIL, OCP_RESP_ERR: begin
              state   <= ST_FIN;
              o_error <= 1'b1;
            end
            default: ; // NULL: keep waiting for the response
          endcase
        end

        ST_WR_CMD: begin
          if (i_SCmdAccept) begin
            state     <= ST_WR_RESP;
            o_MCmd    <= OCP_CMD_IDLE;
            o_MByteEn <= '0;
          end
        end

        ST_WR_RESP: begin
          case (i_SResp)
            OCP_RESP_DVA: begin
              src_q       <= src_next;
              dst_q       <= dst_next;
              remaining_q <= remaining_q - CNT_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                state <= ST_FIN;
              end else begin
                state     <= ST_RD_CMD;
                o_MCmd    <= OCP_CMD_READ;
                o_MAddr   <= src_next;
                o_MByteEn <= BEN_ALL;
              end
            end
            OCP_RESP_FAIL, OCP_RESP_ERR: begin
              state   <= ST_FIN;
              o_error <= 1'b1;
            end
            default: ;
          endcase
        end

        ST_FIN: begin
          state  <= ST_IDLE;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          o_busy    <= 1'b0;
          o_MCmd    <= OCP_CMD_IDLE;
          o_MByteEn <= '0;
        end
      endcase
    end
  end

endmodule : ocp_copy_engine

// File: tb/tb_ocp_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_ocp_copy_engine
//   Directed bench for ocp_copy_engine with a behavioural OCP slave:
//   reads come from src_mem, writes land in dst_mem (both word-indexed by
//   address bits [13:2]). The slave accepts immediately and answers DVA on the
//   next cycle unless told to stall a read, delay read responses or return ERR
//   on a chosen write. Cycle counting: the cycle in which i_start is sampled is
//   cycle 0; o_done seen just after posedge k means "done in cycle k+1".
//   With OCP_COPY_CSUM_EN defined the o_csum port is connected and checked.
// ---------------------------------------------------------------------------
module tb_ocp_copy_engine;
  import ocp_copy_engine_pkg::*;

  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic                  i_start = 1'b0;
  logic [ADDR_WIDTH-1:0] i_src_addr = '0;
  logic [ADDR_WIDTH-1:0] i_dst_addr = '0;
  logic [CNT_W-1:0]      i_count = '0;
  logic                  o_busy, o_done, o_error;
  logic [ADDR_WIDTH-1:0] o_MAddr;
  logic [2:0]            o_MCmd;
  logic [DATA_WIDTH-1:0] o_MData;
  logic [BEN_WIDTH-1:0]  o_MByteEn;
  logic                  s_accept;
  logic [DATA_WIDTH-1:0] s_data = '0;
  logic [1:0]            s_resp = OCP_RESP_NULL;
`ifdef OCP_COPY_CSUM_EN
  logic [DATA_WIDTH-1:0] o_csum;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ocp_copy_engine #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_start      (i_start),
    .i_src_addr   (i_src_addr),
    .i_dst_addr   (i_dst_addr),
    .i_count      (i_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_MAddr      (o_MAddr),
    .o_MCmd       (o_MCmd),
    .o_MData      (o_MData),
    .o_MByteEn    (o_MByteEn),
    .i_SCmdAccept (s_accept),
    .i_SData      (s_data),
    .i_SResp      (s_resp)
`ifdef OCP_COPY_CSUM_EN
    ,
    .o_csum       (o_csum)
`endif
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] src_mem [0:4095];
  logic [31:0] dst_mem [0:4095];
  logic [31:0] rd_log  [0:255];
  int rd_cnt = 0, wr_cnt = 0, cmd_cycles = 0;
  int stall_at = 0, stall_len = 0, stall_ctr = 0, stall_bad = 0;
  int err_wr_at = 0, rd_delay = 0, dly = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] held_addr = '0;
  logic [2:0]  held_cmd = '0;

  assign s_accept = !(o_MCmd == OCP_CMD_READ && (rd_cnt + 1) == stall_at && stall_ctr < stall_len);

  always @(posedge clk) begin
    s_resp <= OCP_RESP_NULL;
    if (pend) begin
      if (dly == 0) begin
        s_resp <= OCP_RESP_DVA;
        s_data <= pend_data;
        pend   <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end
    if (o_MCmd != OCP_CMD_IDLE) cmd_cycles <= cmd_cycles + 1;
    if (stall_ctr != 0 && (o_MCmd != held_cmd || o_MAddr != held_addr)) stall_bad <= stall_bad + 1;
    if (o_MCmd == OCP_CMD_READ) begin
      if (!s_accept) begin
        if (stall_ctr == 0) begin
          held_cmd  <= o_MCmd;
          held_addr <= o_MAddr;
        end
        stall_ctr <= stall_ctr + 1;
      end else begin
        stall_ctr <= 0;
        rd_log[rd_cnt[7:0]] <= o_MAddr;
        rd_cnt <= rd_cnt + 1;
        if (rd_delay == 0) begin
          s_resp <= OCP_RESP_DVA;
          s_data <= src_mem[o_MAddr[13:2]];
        end else begin
          pend      <= 1'b1;
          dly       <= rd_delay - 1;
          pend_data <= src_mem[o_MAddr[13:2]];
        end
      end
    end else if (o_MCmd == OCP_CMD_WRITE) begin
      wr_cnt <= wr_cnt + 1;
      if ((wr_cnt + 1) == err_wr_at) begin
        s_resp <= OCP_RESP_ERR;
      end else begin
        dst_mem[o_MAddr[13:2]] <= o_MData;
        s_resp <= OCP_RESP_DVA;
      end
    end
  end

  // Starts a copy and waits (bounded) for o_done. cycles = -1 on timeout.
  // poke_at >= 0 pulses i_start with different arguments mid-transfer.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int count,
                          input int poke_at, output int cycles, output logic busy0);
    cycles = -1;
    @(negedge clk);
    i_start    = 1'b1;
    i_src_addr = src;
    i_dst_addr = dst;
    i_count    = CNT_W'(count);
    @(negedge clk);
    i_start = 1'b0;
    busy0   = o_busy;
    for (int k = 0; k < 400 && cycles < 0; k++) begin
      if (k == poke_at) begin
        i_start    = 1'b1;
        i_src_addr = 32'h0000_0800;
        i_dst_addr = 32'h0000_3F00;
        i_count    = '0;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) cycles = k + 1;
      else @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: actual=%0h required=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: actual=%0h required=0", o_done); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL reset_error: actual=%0h required=0", o_error); end
    total++; if (o_MCmd !== OCP_CMD_IDLE) begin bad++; $display("FAIL reset_mcmd: actual=%0h required=0", o_MCmd); end
    total++; if (o_MAddr !== 32'h0) begin bad++; $display("FAIL reset_maddr: actual=%0h required=0", o_MAddr); end
    total++; if (o_MData !== 32'h0) begin bad++; $display("FAIL reset_mdata: actual=%0h required=0", o_MData); end
    total++; if (o_MByteEn !== 4'h0) begin bad++; $display("FAIL reset_mbyteen: actual=%0h required=0", o_MByteEn); end
`ifdef OCP_COPY_CSUM_EN
    total++; if (o_csum !== 32'h0) begin bad++; $display("FAIL reset_csum: actual=%0h required=0", o_csum); end
`endif
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; logic b0; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    run_copy(32'h0, 32'h1000, 3, -1, cyc, b0);
    total++; if (cyc !== 14) begin bad++; $display("FAIL basic_latency: actual=%0d required=14", cyc); end
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start: actual=%0h required=1", b0); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL basic_error: actual=%0h required=0", o_error); end
    total++; if (dst_mem[12'h400] !== 32'hA5A5_0001) begin bad++; $display("FAIL basic_word0: actual=%0h required=a5a50001", dst_mem[12'h400]); end
    total++; if (dst_mem[12'h401] !== 32'h5A5A_0002) begin bad++; $display("FAIL basic_word1: actual=%0h required=5a5a0002", dst_mem[12'h401]); end
    total++; if (dst_mem[12'h402] !== 32'hC3C3_0003) begin bad++; $display("FAIL basic_word2: actual=%0h required=c3c30003", dst_mem[12'h402]); end
    total++; if (rd_cnt - r0 !== 3 || wr_cnt - w0 !== 3) begin bad++; $display("FAIL basic_txn_count: actual=%0d/%0d required=3/3", rd_cnt - r0, wr_cnt - w0); end
    @(negedge clk);
    total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle: actual=%0h/%0h required=0/0", o_done, o_busy); end
  endtask

  task automatic test_zero_count();
    int cyc; logic b0; int c0;
    c0 = cmd_cycles;
    run_copy(32'h0, 32'h1000, 0, -1, cyc, b0);
    total++; if (cyc !== 2) begin bad++; $display("FAIL zero_latency: actual=%0d required=2", cyc); end
    total++; if (cmd_cycles - c0 !== 0) begin bad++; $display("FAIL zero_no_traffic: actual=%0d required=0", cmd_cycles - c0); end
  endtask

  task automatic test_stall();
    int cyc; logic b0; int sb0;
    sb0 = stall_bad;
    stall_at  = rd_cnt + 2;
    stall_len = 5;
    // Unaligned inputs: 0x103 -> 0x100, 0x2002 -> 0x2000.
    run_copy(32'h0000_0103, 32'h0000_2002, 3, -1, cyc, b0);
    stall_len = 0;
    total++; if (cyc !== 19) begin bad++; $display("FAIL stall_latency: actual=%0d required=19", cyc); end
    total++; if (stall_bad - sb0 !== 0) begin bad++; $display("FAIL stall_cmd_stable: actual=%0d required=0", stall_bad - sb0); end
    total++; if (dst_mem[12'h800] !== 32'h0000_D00D) begin bad++; $display("FAIL stall_word0: actual=%0h required=d00d", dst_mem[12'h800]); end
    total++; if (dst_mem[12'h801] !== 32'hEEEE_0E0E) begin bad++; $display("FAIL stall_word1: actual=%0h required=eeee0e0e", dst_mem[12'h801]); end
    total++; if (dst_mem[12'h802] !== 32'hF0F0_1234) begin bad++; $display("FAIL stall_word2: actual=%0h required=f0f01234", dst_mem[12'h802]); end
  endtask

  task automatic test_error();
    int cyc; logic b0; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    err_wr_at = wr_cnt + 2;
    run_copy(32'h0000_0200, 32'h0000_3000, 4, -1, cyc, b0);
    err_wr_at = 0;
    total++; if (cyc !== 10) begin bad++; $display("FAIL err_latency: actual=%0d required=10", cyc); end
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL err_flag: actual=%0h required=1", o_error); end
    total++; if (rd_cnt - r0 !== 2 || wr_cnt - w0 !== 2) begin bad++; $display("FAIL err_txn_count: actual=%0d/%0d required=2/2", rd_cnt - r0, wr_cnt - w0); end
    total++; if (dst_mem[12'hC00] !== 32'h8000_0000) begin bad++; $display("FAIL err_word0: actual=%0h required=80000000", dst_mem[12'hC00]); end
    repeat (3) @(negedge clk);
    total++; if (o_error !== 1'b1 || o_MCmd !== OCP_CMD_IDLE) begin bad++; $display("FAIL err_sticky_idle: actual=%0h/%0h required=1/0", o_error, o_MCmd); end
    run_copy(32'h0000_0200, 32'h0000_3400, 1, -1, cyc, b0);
    total++; if (o_error !== 1'b0 || cyc !== 6) begin bad++; $display("FAIL err_cleared_by_start: actual=%0h/%0d required=0/6", o_error, cyc); end
    total++; if (dst_mem[12'hD00] !== 32'h8000_0000) begin bad++; $display("FAIL err_recover_word: actual=%0h required=80000000", dst_mem[12'hD00]); end
  endtask

  task automatic test_busy_start_and_reset();
    int cyc; logic b0; int w0, c0, junk;
    w0 = wr_cnt;
    run_copy(32'h0, 32'h0000_1400, 3, 5, cyc, b0);
    total++; if (cyc !== 14 || wr_cnt - w0 !== 3) begin bad++; $display("FAIL busy_start_ignored: actual=%0d/%0d required=14/3", cyc, wr_cnt - w0); end
    total++; if (dst_mem[12'h502] !== 32'hC3C3_0003) begin bad++; $display("FAIL busy_start_word2: actual=%0h required=c3c30003", dst_mem[12'h502]); end
    // Reset while the engine waits for a slow read response.
    rd_delay = 6;
    @(negedge clk);
    i_start = 1'b1; i_src_addr = 32'h0; i_dst_addr = 32'h0000_1C00; i_count = CNT_W'(2);
    @(negedge clk); i_start = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0 || o_MCmd !== OCP_CMD_IDLE || o_MByteEn !== 4'h0) begin bad++; $display("FAIL rst_mid_ctrl: actual=%0h/%0h/%0h required=0/0/0", o_busy, o_MCmd, o_MByteEn); end
    total++; if (o_MAddr !== 32'h0 || o_MData !== 32'h0) begin bad++; $display("FAIL rst_mid_bus: actual=%0h/%0h required=0/0", o_MAddr, o_MData); end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    c0 = cmd_cycles; junk = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_busy || o_done || o_error) junk++;
    end
    total++; if (junk !== 0 || cmd_cycles - c0 !== 0) begin bad++; $display("FAIL rst_stale_resp_ignored: actual=%0d/%0d required=0/0", junk, cmd_cycles - c0); end
    rd_delay = 0;
    run_copy(32'h0000_0104, 32'h0000_1C00, 1, -1, cyc, b0);
    total++; if (cyc !== 6 || dst_mem[12'h700] !== 32'hEEEE_0E0E) begin bad++; $display("FAIL rst_then_copy: actual=%0d/%0h required=6/eeee0e0e", cyc, dst_mem[12'h700]); end
  endtask

  task automatic test_wrap();
    int cyc; logic b0; int r0; int r1;
    r0 = rd_cnt; r1 = rd_cnt + 1;
    run_copy(32'hFFFF_FFFC, 32'h0000_1800, 2, -1, cyc, b0);
    total++; if (rd_log[r0[7:0]] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_rd0_addr: actual=%0h required=fffffffc", rd_log[r0[7:0]]); end
    total++; if (rd_log[r1[7:0]] !== 32'h0) begin bad++; $display("FAIL wrap_rd1_addr: actual=%0h required=0", rd_log[r1[7:0]]); end
    total++; if (dst_mem[12'h600] !== 32'h7777_FFFC || dst_mem[12'h601] !== 32'hA5A5_0001) begin bad++; $display("FAIL wrap_data: actual=%0h/%0h required=7777fffc/a5a50001", dst_mem[12'h600], dst_mem[12'h601]); end
    total++; if (cyc !== 10 || o_error !== 1'b0) begin bad++; $display("FAIL wrap_latency: actual=%0d/%0h required=10/0", cyc, o_error); end
  endtask

`ifdef OCP_COPY_CSUM_EN
  task automatic test_csum();
    int cyc; logic b0;
    run_copy(32'h0000_2400, 32'h0000_2800, 2, -1, cyc, b0);
    total++; if (o_csum !== 32'hF00F_F00F) begin bad++; $display("FAIL csum_value: actual=%0h required=f00ff00f", o_csum); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) src_mem[i] = 32'h0;
    src_mem[12'h000] = 32'hA5A5_0001;
    src_mem[12'h001] = 32'h5A5A_0002;
    src_mem[12'h002] = 32'hC3C3_0003;
    src_mem[12'h040] = 32'h0000_D00D;
    src_mem[12'h041] = 32'hEEEE_0E0E;
    src_mem[12'h042] = 32'hF0F0_1234;
    src_mem[12'h080] = 32'h8000_0000;
    src_mem[12'h081] = 32'h8000_0001;
    src_mem[12'h082] = 32'h8000_0002;
    src_mem[12'h083] = 32'h8000_0003;
    src_mem[12'h900] = 32'h0F0F_0F0F;
    src_mem[12'h901] = 32'hFF00_FF00;
    src_mem[12'hFFF] = 32'h7777_FFFC;

    test_reset();
    test_basic();
    test_zero_count();
    test_stall();
    test_error();
    test_busy_start_and_reset();
    test_wrap();
`ifdef OCP_COPY_CSUM_EN
    test_csum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ocp_copy_engine
